mod_exp_il_ctrl: RTL and testbench

//  Left-to-right square-and-multiply modular exponentiation controller: result = base^exp mod m.

---
 rtl/mod_exp_il_ctrl_pkg.sv | 21 ++
 rtl/mod_exp_il_ctrl_if.sv | 26 ++
 rtl/mod_exp_il_ctrl_scan.sv | 41 ++++
 rtl/mod_exp_il_ctrl.sv | 154 +++++++++++++++
 tb/tb_mod_exp_il_ctrl.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/mod_exp_il_ctrl_pkg.sv
// Shared definitions for the square-and-multiply exponentiation controller:
// default widths, watchdog limit and the FSM state type.
package mod_exp_il_ctrl_pkg;

  localparam int unsigned DEF_NBITS   = 4;
  localparam int unsigned DEF_EBITS   = 4;
  localparam int unsigned DEF_TIMEOUT = 256;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SCAN,
    ST_SQ_REQ,
    ST_SQ_WAIT,
    ST_ML_REQ,
    ST_ML_WAIT,
    ST_FIN,
    ST_ERR
  } state_t;

endpackage

// File: rtl/mod_exp_il_ctrl_if.sv
// Start/done request bus between the exponentiation controller (master)
// and one interleaved mod-mul core (slave).
interface mod_exp_il_ctrl_if
  import mod_exp_il_ctrl_pkg::*;
#(
  parameter int unsigned NBITS = DEF_NBITS
);

  logic             mul_enable_p;
  logic [NBITS-1:0] mul_a;
  logic [NBITS-1:0] mul_b;
  logic [NBITS-1:0] mul_m;
  logic [NBITS-1:0] mul_y;
  logic             mul_done_p;

  modport master (
    output mul_enable_p, mul_a, mul_b, mul_m,
    input  mul_y, mul_done_p
  );

  modport slave (
    input  mul_enable_p, mul_a, mul_b, mul_m,
    output mul_y, mul_done_p
  );

endinterface

// File: rtl/mod_exp_il_ctrl_scan.sv
// Exponent shift register and remaining-bit counter; the bit under
// consideration is always the MSB of the shift register.
module mod_exp_il_ctrl_scan
  import mod_exp_il_ctrl_pkg::*;
#(
  parameter int unsigned EBITS = DEF_EBITS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [EBITS-1:0] i_exp,
  input  logic             i_shift,
  output logic             o_cur_bit,
  output logic             o_last_bit,
  output logic             o_zero
);

  localparam int unsigned CNTW = $clog2(EBITS + 1);

  logic [EBITS-1:0] r_e;
  logic [CNTW-1:0]  r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_e   <= '0;
      r_cnt <= '0;
    end else if (i_load) begin
      r_e   <= i_exp;
      r_cnt <= CNTW'(EBITS);
    end else if (i_shift) begin
      r_e   <= r_e << 1;
      r_cnt <= r_cnt - CNTW'(1);
    end
  end

  assign o_cur_bit  = r_e[EBITS-1];
  // Consuming the bit while one remains leaves the counter at zero.
  assign o_last_bit = (r_cnt == CNTW'(1));
  assign o_zero     = (r_e == '0);

endmodule

// File: rtl/mod_exp_il_ctrl.sv
// Left-to-right square-and-multiply controller computing base^exp mod m
// by issuing square/multiply requests to an external mod-mul core.
module mod_exp_il_ctrl
  import mod_exp_il_ctrl_pkg::*;
#(
  parameter int unsigned NBITS   = DEF_NBITS,
  parameter int unsigned EBITS   = DEF_EBITS,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_p,
  input  logic [NBITS-1:0] base,
  input  logic [EBITS-1:0] exp,
  input  logic [NBITS-1:0] m,
  output logic [NBITS-1:0] result,
  output logic             busy,
  output logic             done_p,
  output logic             err_p,
  mod_exp_il_ctrl_if.master mul
);

  localparam int unsigned WDW = $clog2(TIMEOUT + 1);

  state_t           r_state, w_nxt;
  logic [NBITS-1:0] r_b, r_m, r_r, r_result, r_mul_a, r_mul_b;
  logic [NBITS-1:0] w_r_nxt;
  logic [WDW-1:0]   r_wd;
  logic             w_load, w_shift, w_cur, w_last, w_zero, w_expire;

  mod_exp_il_ctrl_scan #(.EBITS(EBITS)) u_scan (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_load),
    .i_exp      (exp),
    .i_shift    (w_shift),
    .o_cur_bit  (w_cur),
    .o_last_bit (w_last),
    .o_zero     (w_zero)
  );

  assign w_expire = (r_wd == WDW'(TIMEOUT - 1));

  always_comb begin
    w_nxt   = r_state;
    w_r_nxt = r_r;
    w_load  = 1'b0;
    w_shift = 1'b0;
    case (r_state)
      ST_IDLE: if (start_p) begin
        w_load = 1'b1;
        w_nxt  = ST_LOAD;
      end
      ST_LOAD: begin
        if (r_m == '0) begin
          w_nxt = ST_ERR;
        end else if (r_m == NBITS'(1)) begin
          w_r_nxt = '0;
          w_nxt   = ST_FIN;
        end else if (w_zero) begin
          w_r_nxt = NBITS'(1);
          w_nxt   = ST_FIN;
        end else begin
          w_nxt = ST_SCAN;
        end
      end
      ST_SCAN: begin
        w_shift = 1'b1;
        if (w_cur) begin
          w_r_nxt = r_b;
          w_nxt   = w_last ? ST_FIN : ST_SQ_REQ;
        end
      end
      ST_SQ_REQ: w_nxt = ST_SQ_WAIT;
      ST_SQ_WAIT: begin
        if (mul.mul_done_p) begin
          w_r_nxt = mul.mul_y;
          if (w_cur) begin
            w_nxt = ST_ML_REQ;
          end else begin
            w_shift = 1'b1;
            w_nxt   = w_last ? ST_FIN : ST_SQ_REQ;
          end
        end else if (w_expire) begin
          w_nxt = ST_ERR;
        end
      end
      ST_ML_REQ: w_nxt = ST_ML_WAIT;
      ST_ML_WAIT: begin
        if (mul.mul_done_p) begin
          w_r_nxt = mul.mul_y;
          w_shift = 1'b1;
          w_nxt   = w_last ? ST_FIN : ST_SQ_REQ;
        end else if (w_expire) begin
          w_nxt = ST_ERR;
        end
      end
      ST_FIN:  w_nxt = ST_IDLE;
      ST_ERR:  w_nxt = ST_IDLE;
      default: w_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_b      <= '0;
      r_m      <= '0;
      r_r      <= '0;
      r_result <= '0;
      r_mul_a  <= '0;
      r_mul_b  <= '0;
      r_wd     <= '0;
    end else begin
      r_state <= w_nxt;
      r_r     <= w_r_nxt;
      if (w_load) begin
        r_b <= base;
        r_m <= m;
      end
      // Operands are loaded on entry to a request so they are already
      // valid during the enable cycle and stay put until the product returns.
      if (w_nxt == ST_SQ_REQ) begin
        r_mul_a <= w_r_nxt;
        r_mul_b <= w_r_nxt;
      end else if (w_nxt == ST_ML_REQ) begin
        r_mul_a <= w_r_nxt;
        r_mul_b <= r_b;
      end
      if (r_state == ST_SQ_REQ || r_state == ST_ML_REQ) begin
        r_wd <= '0;
      end else if (r_state == ST_SQ_WAIT || r_state == ST_ML_WAIT) begin
        r_wd <= r_wd + WDW'(1);
      end
      if (r_state == ST_FIN) begin
        r_result <= r_r;
      end else if (r_state == ST_ERR) begin
        r_result <= '0;
      end
    end
  end

  assign mul.mul_enable_p = (r_state == ST_SQ_REQ) || (r_state == ST_ML_REQ);
  assign mul.mul_a        = r_mul_a;
  assign mul.mul_b        = r_mul_b;
  assign mul.mul_m        = r_m;

  assign busy   = !(r_state == ST_IDLE || r_state == ST_FIN || r_state == ST_ERR);
  assign done_p = (r_state == ST_FIN);
  assign err_p  = (r_state == ST_ERR);
  assign result = (r_state == ST_FIN) ? r_r :
                  (r_state == ST_ERR) ? '0  : r_result;

endmodule

// File: tb/tb_mod_exp_il_ctrl.sv
// Directed bench for mod_exp_il_ctrl with a behavioural mod-mul model of
// programmable latency and an option to withhold the product.
module tb_mod_exp_il_ctrl;
  import mod_exp_il_ctrl_pkg::*;

  localparam int unsigned NB = 4;
  localparam int unsigned EB = 4;
  localparam int unsigned TO = 12;

  typedef struct {
    logic [NB-1:0] b;
    logic [EB-1:0] e;
    logic [NB-1:0] m;
    logic [NB-1:0] res;
    int            nmul;
    bit            err;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start_p;
  logic [NB-1:0] base;
  logic [EB-1:0] exp_in;
  logic [NB-1:0] m;
  logic [NB-1:0] result;
  logic          busy, done_p, err_p;

  mod_exp_il_ctrl_if #(.NBITS(NB)) mif ();

  mod_exp_il_ctrl #(.NBITS(NB), .EBITS(EB), .TIMEOUT(TO)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_p (start_p),
    .base    (base),
    .exp     (exp_in),
    .m       (m),
    .result  (result),
    .busy    (busy),
    .done_p  (done_p),
    .err_p   (err_p),
    .mul     (mif)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int n_en  = 0;
  int lat   = 2;
  bit withhold = 1'b0;

  always @(negedge clk) n_en <= n_en + int'(mif.mul_enable_p);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // Behavioural multiplier: product (a*b) mod m returned lat cycles after enable.
  initial begin
    logic          pend;
    int            cnt;
    logic [NB-1:0] ca, cb, cm;
    pend = 1'b0;
    cnt  = 0;
    ca = '0; cb = '0; cm = '0;
    mif.mul_done_p = 1'b0;
    mif.mul_y      = '0;
    forever begin
      @(posedge clk);
      #1;
      mif.mul_done_p = 1'b0;
      if (!rst_n) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          cnt--;
          if (cnt == 0) begin
            pend = 1'b0;
            if (!withhold) begin
              check("op_stable", {20'd0, mif.mul_a, mif.mul_b, mif.mul_m}, {20'd0, ca, cb, cm});
              mif.mul_y      = (cm == '0) ? '0 : NB'((int'(ca) * int'(cb)) % int'(cm));
              mif.mul_done_p = 1'b1;
            end
          end
        end
        if (mif.mul_enable_p) begin
          check("en_reassert", {31'd0, pend}, 0);
          pend = 1'b1;
          cnt  = lat;
          ca = mif.mul_a; cb = mif.mul_b; cm = mif.mul_m;
        end
      end
    end
  end

  task automatic run_vec(input vec_t v, input string tag, input bit poke, output int latency);
    int en0, t;
    @(negedge clk);
    base = v.b; exp_in = v.e; m = v.m; start_p = 1'b1;
    en0 = n_en;
    @(negedge clk);
    start_p = 1'b0;
    t = 1;
    check({tag, "_busy_start"}, {31'd0, busy}, 1);
    if (poke) begin
      @(negedge clk);
      base = 4'd2; exp_in = 4'd1; m = 4'd5; start_p = 1'b1;
      @(negedge clk);
      start_p = 1'b0;
      t += 2;
    end
    while (!(done_p || err_p) && t < 300) begin
      @(negedge clk);
      t++;
    end
    latency = t;
    if (!(done_p || err_p)) begin
      check({tag, "_completion"}, 0, 1);
    end else begin
      check({tag, "_done_p"}, {31'd0, done_p}, {31'd0, !v.err});
      check({tag, "_err_p"}, {31'd0, err_p}, {31'd0, v.err});
      check({tag, "_result"}, {28'd0, result}, {28'd0, v.res});
      check({tag, "_busy_end"}, {31'd0, busy}, 0);
      @(negedge clk);
      check({tag, "_pulse_once"}, {31'd0, done_p | err_p}, 0);
      check({tag, "_result_held"}, {28'd0, result}, {28'd0, v.res});
      check({tag, "_n_mul"}, n_en - en0, v.nmul);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return {4'd0, result, busy, done_p, err_p, mif.mul_enable_p,
            mif.mul_a, mif.mul_b, mif.mul_m};
  endfunction

  vec_t vecs [12];
  vec_t v75;

  initial begin
    int   l;
    int   t;
    logic stray;
    vecs[0]  = '{4'd7,  4'd5,  4'd13, 4'd11, 3, 1'b0};
    vecs[1]  = '{4'd5,  4'd0,  4'd13, 4'd1,  0, 1'b0};
    vecs[2]  = '{4'd0,  4'd3,  4'd1,  4'd0,  0, 1'b0};
    vecs[3]  = '{4'd0,  4'd3,  4'd13, 4'd0,  2, 1'b0};
    vecs[4]  = '{4'd12, 4'd15, 4'd13, 4'd12, 6, 1'b0};
    vecs[5]  = '{4'd3,  4'd4,  4'd7,  4'd4,  2, 1'b0};
    vecs[6]  = '{4'd2,  4'd8,  4'd11, 4'd3,  3, 1'b0};
    vecs[7]  = '{4'd5,  4'd3,  4'd0,  4'd0,  0, 1'b1};
    vecs[8]  = '{4'd9,  4'd1,  4'd10, 4'd9,  0, 1'b0};
    vecs[9]  = '{4'd6,  4'd6,  4'd7,  4'd1,  3, 1'b0};
    vecs[10] = '{4'd14, 4'd2,  4'd15, 4'd1,  1, 1'b0};
    vecs[11] = '{4'd0,  4'd0,  4'd1,  4'd0,  0, 1'b0};
    v75      = '{4'd7,  4'd5,  4'd13, 4'd11, 3, 1'b0};

    rst_n = 1'b0; start_p = 1'b0; base = '0; exp_in = '0; m = '0;
    #1;
    check("reset_outputs", all_outs(), 0);
    repeat (2) @(negedge clk);
    check("reset_outputs_held", all_outs(), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      run_vec(vecs[i], $sformatf("v%0d", i), 1'b0, l);
    end

    // Valid run after m=0 error, with latency 3 + lz + 3*(1+lat)
    run_vec(v75, "after_err", 1'b0, l);
    check("latency_7_5", l, 13);

    // Product withheld: err_p TIMEOUT cycles after SQ_WAIT entry (cycle 5)
    withhold = 1'b1;
    run_vec('{4'd7, 4'd5, 4'd13, 4'd0, 1, 1'b1}, "timeout", 1'b0, l);
    check("timeout_latency", l, 5 + TO);
    withhold = 1'b0;
    run_vec(v75, "after_timeout", 1'b0, l);

    // Product arrives on the watchdog expiry cycle: no error
    lat = TO;
    run_vec(v75, "expiry_race", 1'b0, l);
    check("expiry_race_latency", l, 3 + 1 + 3 * (1 + TO));
    lat = 2;

    // Second start while busy is ignored
    run_vec(v75, "start_busy", 1'b1, l);

    // Reset asserted while waiting for a square
    @(negedge clk);
    base = 4'd7; exp_in = 4'd5; m = 4'd13; start_p = 1'b1;
    @(negedge clk);
    start_p = 1'b0;
    t = 0;
    while (!mif.mul_enable_p && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("saw_enable", {31'd0, mif.mul_enable_p}, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("reset_in_wait", all_outs(), 0);
    @(negedge clk);
    rst_n = 1'b1;
    stray = 1'b0;
    repeat (10) begin
      @(negedge clk);
      stray = stray | done_p | err_p | busy | mif.mul_enable_p;
    end
    check("no_activity_after_reset", {31'd0, stray}, 0);
    run_vec(vecs[9], "after_reset", 1'b0, l);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
